// File: rtl/reg_file_pkg.sv
// Shared sizes and types for the architectural register file and its rename table.
package reg_file_pkg;
    localparam int REG_NUM   = 32;
    localparam int ROB_SIZE  = 16;
    localparam int REG_IDX_W = $clog2(REG_NUM);
    localparam int ROB_ID_W  = $clog2(ROB_SIZE);
    localparam int DATA_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [ROB_ID_W-1:0]  rob_id_t;
    typedef logic [DATA_W-1:0]    data_t;

    localparam rob_id_t  NO_ALIAS  = '0;
    localparam data_t    ZERO_DATA = '0;
    localparam reg_idx_t REG_X0    = '0;
endpackage

// File: rtl/reg_file_read_port.sv
// One dispatcher source-operand port: x0 masking plus forwarding of the retiring result.
module reg_read_port
    import reg_file_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs_i,
    input  logic                 commit_vld_i,
    input  logic [REG_IDX_W-1:0] commit_idx_i,
    input  logic [DATA_W-1:0]    commit_val_i,
    input  logic [ROB_ID_W-1:0]  commit_alias_i,
    input  logic [ROB_ID_W-1:0]  reg_alias_i,
    input  logic [DATA_W-1:0]    reg_val_i,
    output logic [ROB_ID_W-1:0]  q_o,
    output logic [DATA_W-1:0]    v_o
);

    // Forward only when the committing entry is the newest producer of rs.
    always_comb begin
        q_o = reg_alias_i;
        v_o = reg_val_i;
        if (rs_i == REG_X0) begin
            q_o = NO_ALIAS;
            v_o = ZERO_DATA;
        end else if (commit_vld_i && (commit_idx_i == rs_i) && (reg_alias_i == commit_alias_i)) begin
            q_o = NO_ALIAS;
            v_o = commit_val_i;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename table; written by ROB commit and dispatcher rename.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback_signal,
    input  logic                 res_rdy_from_rob,
    input  logic [REG_IDX_W-1:0] regidx_from_rob,
    input  logic [DATA_W-1:0]    res_from_rob,
    input  logic [ROB_ID_W-1:0]  alias_from_rob,
    input  logic                 rename_ena_from_dsp,
    input  logic [REG_IDX_W-1:0] rd_from_dsp,
    input  logic [ROB_ID_W-1:0]  renameid_from_dsp,
    input  logic [REG_IDX_W-1:0] rs1_from_dsp,
    input  logic [REG_IDX_W-1:0] rs2_from_dsp,
    output logic [ROB_ID_W-1:0]  Qi_2dsp,
    output logic [ROB_ID_W-1:0]  Qj_2dsp,
    output logic [DATA_W-1:0]    Vi_2dsp,
    output logic [DATA_W-1:0]    Vj_2dsp
);

    data_t   val_q   [REG_NUM];
    data_t   val_d   [REG_NUM];
    rob_id_t alias_q [REG_NUM];
    rob_id_t alias_d [REG_NUM];

    logic commit_vld;
    logic commit_wr;
    logic rename_wr;

    assign commit_vld = res_rdy_from_rob && rdy;
    assign commit_wr  = commit_vld && (regidx_from_rob != REG_X0);
    assign rename_wr  = rdy && rename_ena_from_dsp && (rd_from_dsp != REG_X0);

    // Values always take the commit; the flush overrides every alias update, and rename beats a clear.
    always_comb begin
        val_d   = val_q;
        alias_d = alias_q;
        if (commit_wr) begin
            val_d[regidx_from_rob] = res_from_rob;
        end
        if (rollback_signal) begin
            for (int i = 0; i < REG_NUM; i++) begin
                alias_d[i] = NO_ALIAS;
            end
        end else begin
            if (commit_wr && (alias_q[regidx_from_rob] == alias_from_rob)) begin
                alias_d[regidx_from_rob] = NO_ALIAS;
            end
            if (rename_wr) begin
                alias_d[rd_from_dsp] = renameid_from_dsp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]   <= ZERO_DATA;
                alias_q[i] <= NO_ALIAS;
            end
        end else begin
            val_q   <= val_d;
            alias_q <= alias_d;
        end
    end

    reg_read_port u_rs1_port (
        .rs_i           (rs1_from_dsp),
        .commit_vld_i   (commit_vld),
        .commit_idx_i   (regidx_from_rob),
        .commit_val_i   (res_from_rob),
        .commit_alias_i (alias_from_rob),
        .reg_alias_i    (alias_q[rs1_from_dsp]),
        .reg_val_i      (val_q[rs1_from_dsp]),
        .q_o            (Qi_2dsp),
        .v_o            (Vi_2dsp)
    );

    reg_read_port u_rs2_port (
        .rs_i           (rs2_from_dsp),
        .commit_vld_i   (commit_vld),
        .commit_idx_i   (regidx_from_rob),
        .commit_val_i   (res_from_rob),
        .commit_alias_i (alias_from_rob),
        .reg_alias_i    (alias_q[rs2_from_dsp]),
        .reg_val_i      (val_q[rs2_from_dsp]),
        .q_o            (Qj_2dsp),
        .v_o            (Vj_2dsp)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios, then randomized traffic against a register/alias model.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rollback_signal;
   logic        res_rdy_from_rob;
   logic [4:0]  regidx_from_rob;
   logic [31:0] res_from_rob;
   logic [3:0]  alias_from_rob;
   logic        rename_ena_from_dsp;
   logic [4:0]  rd_from_dsp;
   logic [3:0]  renameid_from_dsp;
   logic [4:0]  rs1_from_dsp;
   logic [4:0]  rs2_from_dsp;
   logic [3:0]  Qi_2dsp;
   logic [3:0]  Qj_2dsp;
   logic [31:0] Vi_2dsp;
   logic [31:0] Vj_2dsp;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [31:0] modelVal   [32];
   logic [3:0]  modelAlias [32];

   reg_file dut (
      .clk                 (clk),
      .rst                 (rst),
      .rdy                 (rdy),
      .rollback_signal     (rollback_signal),
      .res_rdy_from_rob    (res_rdy_from_rob),
      .regidx_from_rob     (regidx_from_rob),
      .res_from_rob        (res_from_rob),
      .alias_from_rob      (alias_from_rob),
      .rename_ena_from_dsp (rename_ena_from_dsp),
      .rd_from_dsp         (rd_from_dsp),
      .renameid_from_dsp   (renameid_from_dsp),
      .rs1_from_dsp        (rs1_from_dsp),
      .rs2_from_dsp        (rs2_from_dsp),
      .Qi_2dsp             (Qi_2dsp),
      .Qj_2dsp             (Qj_2dsp),
      .Vi_2dsp             (Vi_2dsp),
      .Vj_2dsp             (Vj_2dsp)
   );

   // Free-running 10-unit clock.
   initial forever #5 clk = ~clk;

   // Hard time limit so a stuck run still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Clears the model the way an asynchronous reset clears the register file.
   task automatic resetModel();
      for (int i = 0; i < 32; i++) begin
         modelVal[i]   = '0;
         modelAlias[i] = '0;
      end
   endtask

   // Expected query answer, straight from the source-read rules.
   task automatic expectQuery(input logic [4:0] rs, output logic [3:0] q, output logic [31:0] v);
      if (rs == 5'd0) begin
         q = '0;
         v = '0;
      end else if (res_rdy_from_rob && rdy && regidx_from_rob == rs && modelAlias[rs] == alias_from_rob) begin
         q = '0;
         v = res_from_rob;
      end else begin
         q = modelAlias[rs];
         v = modelVal[rs];
      end
   endtask

   task automatic setIdle();
      rdy                 = 1'b1;
      rollback_signal     = 1'b0;
      res_rdy_from_rob    = 1'b0;
      regidx_from_rob     = '0;
      res_from_rob        = '0;
      alias_from_rob      = '0;
      rename_ena_from_dsp = 1'b0;
      rd_from_dsp         = '0;
      renameid_from_dsp   = '0;
      rs1_from_dsp        = '0;
      rs2_from_dsp        = '0;
   endtask

   // Checks the live query outputs against the model, clocks once, then advances the model.
   task automatic applyStimulus(input string tag);
      logic [3:0]  eq;
      logic [31:0] ev;
      logic [31:0] nVal   [32];
      logic [3:0]  nAlias [32];
      logic        commitOk;
      #1;
      expectQuery(rs1_from_dsp, eq, ev);
      checkOutput({tag, "_Qi"}, {28'd0, Qi_2dsp}, {28'd0, eq});
      checkOutput({tag, "_Vi"}, Vi_2dsp, ev);
      expectQuery(rs2_from_dsp, eq, ev);
      checkOutput({tag, "_Qj"}, {28'd0, Qj_2dsp}, {28'd0, eq});
      checkOutput({tag, "_Vj"}, Vj_2dsp, ev);
      nVal     = modelVal;
      nAlias   = modelAlias;
      commitOk = rdy && res_rdy_from_rob && regidx_from_rob != 5'd0;
      if (commitOk) nVal[regidx_from_rob] = res_from_rob;
      if (rollback_signal) begin
         for (int i = 0; i < 32; i++) nAlias[i] = '0;
      end else if (rdy) begin
         if (commitOk && modelAlias[regidx_from_rob] == alias_from_rob) nAlias[regidx_from_rob] = '0;
         if (rename_ena_from_dsp && rd_from_dsp != 5'd0) nAlias[rd_from_dsp] = renameid_from_dsp;
      end
      @(posedge clk);
      #1;
      modelVal   = nVal;
      modelAlias = nAlias;
   endtask

   task automatic doCommit(input logic [4:0] idx, input logic [3:0] id, input logic [31:0] value);
      setIdle();
      res_rdy_from_rob = 1'b1;
      regidx_from_rob  = idx;
      alias_from_rob   = id;
      res_from_rob     = value;
      applyStimulus("commit");
   endtask

   task automatic doRename(input logic [4:0] rd, input logic [3:0] id);
      setIdle();
      rename_ena_from_dsp = 1'b1;
      rd_from_dsp         = rd;
      renameid_from_dsp   = id;
      applyStimulus("rename");
   endtask

   // Sets both query ports with idle write paths and waits for the combinational settle.
   task automatic queryRegs(input logic [4:0] a, input logic [4:0] b);
      setIdle();
      rs1_from_dsp = a;
      rs2_from_dsp = b;
      #1;
   endtask

   initial begin
      setIdle();
      rst = 1'b1;
      resetModel();
      #2;
      queryRegs(5'd1, 5'd2);
      checkOutput("reset_Qi", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("reset_Vi", Vi_2dsp, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Scenario 1: asynchronous reset in the middle of a cycle.
      doCommit(5'd5, 4'd0, 32'h1234);
      queryRegs(5'd5, 5'd5);
      checkOutput("t1_pre_V", Vi_2dsp, 32'h1234);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t1_async_Q", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("t1_async_V", Vi_2dsp, 32'd0);
      resetModel();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Scenario 2: newest producer retires and clears its alias.
      doRename(5'd3, 4'd4);
      doCommit(5'd3, 4'd4, 32'hAB);
      queryRegs(5'd3, 5'd0);
      checkOutput("t2_Q", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("t2_V", Vi_2dsp, 32'hAB);
      checkOutput("t2_x0_V", Vj_2dsp, 32'd0);

      // Scenario 3: an older producer writes the value but leaves the newer alias.
      doRename(5'd3, 4'd4);
      doRename(5'd3, 4'd7);
      doCommit(5'd3, 4'd4, 32'h11);
      queryRegs(5'd3, 5'd3);
      checkOutput("t3_Q", {28'd0, Qi_2dsp}, 32'd7);
      checkOutput("t3_V", Vj_2dsp, 32'h11);

      // Scenario 4: same-cycle commit clear and rename of x8.
      doRename(5'd8, 4'd2);
      setIdle();
      res_rdy_from_rob    = 1'b1;
      regidx_from_rob     = 5'd8;
      alias_from_rob      = 4'd2;
      res_from_rob        = 32'hC0FFEE;
      rename_ena_from_dsp = 1'b1;
      rd_from_dsp         = 5'd8;
      renameid_from_dsp   = 4'd5;
      rs1_from_dsp        = 5'd8;
      #1;
      checkOutput("t4_fwd_Q", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("t4_fwd_V", Vi_2dsp, 32'hC0FFEE);
      applyStimulus("t4");
      queryRegs(5'd8, 5'd8);
      checkOutput("t4_after_Q", {28'd0, Qi_2dsp}, 32'd5);

      // Scenario 5: rollback with several aliases live and a commit in the same cycle.
      for (int r = 1; r <= 4; r++) doRename(5'(r), 4'(r + 8));
      setIdle();
      rollback_signal     = 1'b1;
      res_rdy_from_rob    = 1'b1;
      regidx_from_rob     = 5'd1;
      alias_from_rob      = 4'd3;
      res_from_rob        = 32'h55;
      rename_ena_from_dsp = 1'b1;
      rd_from_dsp         = 5'd2;
      renameid_from_dsp   = 4'd6;
      applyStimulus("t5");
      queryRegs(5'd1, 5'd2);
      checkOutput("t5_x1_Q", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("t5_x1_V", Vi_2dsp, 32'h55);
      checkOutput("t5_x2_Q", {28'd0, Qj_2dsp}, 32'd0);
      queryRegs(5'd3, 5'd4);
      checkOutput("t5_x3_Q", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("t5_x4_Q", {28'd0, Qj_2dsp}, 32'd0);

      // Scenario 6: x0 writes, paused commits, and rollback while paused.
      doCommit(5'd0, 4'd0, 32'hFFFF_FFFF);
      doRename(5'd0, 4'd9);
      queryRegs(5'd0, 5'd0);
      checkOutput("t6_x0_Q", {28'd0, Qi_2dsp}, 32'd0);
      checkOutput("t6_x0_V", Vj_2dsp, 32'd0);
      doCommit(5'd9, 4'd0, 32'h99);
      setIdle();
      rdy              = 1'b0;
      res_rdy_from_rob = 1'b1;
      regidx_from_rob  = 5'd9;
      res_from_rob     = 32'hDEAD;
      rs1_from_dsp     = 5'd9;
      #1;
      checkOutput("t6_paused_fwd_V", Vi_2dsp, 32'h99);
      applyStimulus("t6_paused");
      queryRegs(5'd9, 5'd9);
      checkOutput("t6_x9_V", Vi_2dsp, 32'h99);
      doRename(5'd9, 4'd6);
      setIdle();
      rdy             = 1'b0;
      rollback_signal = 1'b1;
      applyStimulus("t6_rb");
      queryRegs(5'd9, 5'd9);
      checkOutput("t6_rb_Q", {28'd0, Qi_2dsp}, 32'd0);

      // Randomized traffic concentrated on a few registers to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         setIdle();
         rdy                 = ($urandom_range(0, 9) != 0);
         rollback_signal     = ($urandom_range(0, 19) == 0);
         res_rdy_from_rob    = $urandom_range(0, 1) == 1;
         regidx_from_rob     = 5'($urandom_range(0, 7));
         res_from_rob        = $urandom;
         alias_from_rob      = ($urandom_range(0, 1) == 1) ? modelAlias[regidx_from_rob] : 4'($urandom_range(0, 15));
         rename_ena_from_dsp = $urandom_range(0, 1) == 1;
         rd_from_dsp         = 5'($urandom_range(0, 7));
         renameid_from_dsp   = 4'($urandom_range(1, 15));
         rs1_from_dsp        = 5'($urandom_range(0, 7));
         rs2_from_dsp        = ($urandom_range(0, 3) == 0) ? regidx_from_rob : 5'($urandom_range(0, 7));
         applyStimulus("rand");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
